// File: rtl/shift_and_subtract_binary_divider.sv
// Sequential restoring divider: (m+n)-bit dividend / n-bit divisor, one quotient
// bit per clock, MSB first, with a start/busy/done handshake and divide-by-zero flag.
module shift_and_subtract_binary_divider #(
    parameter int m = 8,
    parameter int n = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [m+n-1:0]   A,
    input  logic [n-1:0]     B,
    output logic [m+n-1:0]   Q,
    output logic [n-1:0]     R,
    output logic             busy,
    output logic             done,
    output logic             dbz,
    output logic [1:0]       dbg_state_o
);

    localparam int W  = m + n;
    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q;
    logic [W-1:0]    dvd_q;
    logic [n-1:0]    dvs_q;
    logic [n:0]      rem_q;
    logic [W-1:0]    quo_q;
    logic [CW-1:0]   cnt_q;
    logic [W-1:0]    q_q;
    logic [n-1:0]    r_q;
    logic            busy_q;
    logic            done_q;
    logic            dbz_q;

    logic [n:0]      rem_shift;
    logic            sub_ok;
    logic [n:0]      rem_d;
    logic [W-1:0]    quo_d;

    // The partial remainder stays below the divisor, so one extra bit holds
    // the shifted value (at most 2*divisor-1) without overflow.
    always_comb begin
        rem_shift = {rem_q[n-1:0], dvd_q[W-1]};
        sub_ok    = (rem_shift >= {1'b0, dvs_q});
        rem_d     = sub_ok ? (rem_shift - {1'b0, dvs_q}) : rem_shift;
        quo_d     = {quo_q[W-2:0], sub_ok};
    end

    // Handshake: start is accepted on any edge where the block is not in RUN
    // (IDLE or the DONE cycle); busy covers the iterations, done pulses once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            dvd_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    state_q <= S_IDLE;
                    if (start) begin
                        if (B == '0) begin
                            q_q     <= '1;
                            r_q     <= A[n-1:0];
                            dbz_q   <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            dvd_q   <= A;
                            dvs_q   <= B;
                            rem_q   <= '0;
                            quo_q   <= '0;
                            cnt_q   <= CW'(W);
                            busy_q  <= 1'b1;
                            state_q <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    rem_q <= rem_d;
                    dvd_q <= {dvd_q[W-2:0], 1'b0};
                    quo_q <= quo_d;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        q_q     <= quo_d;
                        r_q     <= rem_d[n-1:0];
                        dbz_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign Q           = q_q;
    assign R           = r_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign dbz         = dbz_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_shift_and_subtract_binary_divider.sv
// Bench for the restoring divider: directed cases with literal expectations plus
// randomized back-to-back traffic checked every cycle against a behavioural model.
module tb_shift_and_subtract_binary_divider;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [15:0]   A = '0;
  logic [7:0]    B = '0;
  logic [15:0]   Q;
  logic [7:0]    R;
  logic          busy;
  logic          done;
  logic          dbz;
  logic [1:0]    dbg_state;

  int n_cmp = 0;
  int n_bad = 0;

  shift_and_subtract_binary_divider #(.m(8), .n(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .A           (A),
    .B           (B),
    .Q           (Q),
    .R           (R),
    .busy        (busy),
    .done        (done),
    .dbz         (dbz),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // behavioural model: a result computed with / and % is published W edges
  // after an accepted start; divide-by-zero publishes on the next edge
  int          m_left = 0;
  logic [15:0] p_q = '0;
  logic [7:0]  p_r = '0;
  logic [15:0] m_q = '0;
  logic [7:0]  m_r = '0;
  logic        m_dbz = 1'b0;
  logic        m_done = 1'b0;
  logic        m_busy;

  assign m_busy = (m_left != 0);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left <= 0;
      m_q    <= '0;
      m_r    <= '0;
      m_dbz  <= 1'b0;
      m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_left != 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_q    <= p_q;
          m_r    <= p_r;
          m_dbz  <= 1'b0;
          m_done <= 1'b1;
        end
      end else if (start) begin
        if (B == 8'd0) begin
          m_q    <= 16'hFFFF;
          m_r    <= A[7:0];
          m_dbz  <= 1'b1;
          m_done <= 1'b1;
        end else begin
          p_q    <= A / 16'(B);
          p_r    <= 8'(A % 16'(B));
          m_left <= W;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // compare process: every cycle outside reset
  always @(negedge clk) begin
    if (!rst) begin
      check("busy", 32'(busy), 32'(m_busy));
      check("done", 32'(done), 32'(m_done));
      check("Q", 32'(Q), 32'(m_q));
      check("R", 32'(R), 32'(m_r));
      check("dbz", 32'(dbz), 32'(m_dbz));
    end
  end

  // driver: call between edges (idle or DONE cycle); returns in the done cycle
  task automatic run_op(input logic [15:0] a, input logic [7:0] b,
                        input logic [15:0] eq, input logic [7:0] er,
                        input logic edbz, input string tag);
    int k;
    int nb;
    logic got;
    int elat;
    int ebusy;
    elat  = edbz ? 1 : W + 1;
    ebusy = edbz ? 0 : W;
    A = a;
    B = b;
    start = 1'b1;
    @(posedge clk);
    #2 start = 1'b0;
    k = 0;
    nb = 0;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      k++;
      if (busy) nb++;
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    check({tag, " done seen"}, 32'(got), 32'd1);
    check({tag, " latency"}, k, elat);
    check({tag, " busy cycles"}, nb, ebusy);
    check({tag, " Q"}, 32'(Q), 32'(eq));
    check({tag, " R"}, 32'(R), 32'(er));
    check({tag, " dbz"}, 32'(dbz), 32'(edbz));
    check({tag, " model Q"}, 32'(m_q), 32'(eq));
    check({tag, " model R"}, 32'(m_r), 32'(er));
  endtask

  task automatic run_rand(input logic [15:0] a, input logic [7:0] b);
    logic got;
    A = a;
    B = b;
    start = 1'b1;
    @(posedge clk);
    #2 start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    check("rand done seen", 32'(got), 32'd1);
    check("rand Q*B+R", 32'(Q) * 32'(b) + 32'(R), 32'(a));
    check("rand R<B", 32'(R < b), 32'd1);
    check("rand dbz", 32'(dbz), 32'd0);
  endtask

  initial begin
    int done_cnt;
    logic got;
    logic [15:0] ra;
    logic [7:0]  rb;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset Q", 32'(Q), 32'd0);
    check("reset R", 32'(R), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset dbz", 32'(dbz), 32'd0);
    #1 rst = 1'b0;
    @(negedge clk);

    // directed, back-to-back (each start lands in the previous DONE cycle)
    run_op(16'hFE01, 8'hFF, 16'd255, 8'd0, 1'b0, "fe01/ff");
    run_op(16'd961, 8'd31, 16'd31, 8'd0, 1'b0, "961/31");
    run_op(16'd6, 8'd2, 16'd3, 8'd0, 1'b0, "6/2");
    run_op(16'd1000, 8'd7, 16'd142, 8'd6, 1'b0, "1000/7");
    run_op(16'd5, 8'd9, 16'd0, 8'd5, 1'b0, "5/9");
    run_op(16'hFFFF, 8'd1, 16'hFFFF, 8'd0, 1'b0, "ffff/1");
    run_op(16'd1234, 8'd0, 16'hFFFF, 8'hD2, 1'b1, "1234/0");
    run_op(16'd10, 8'd3, 16'd3, 8'd1, 1'b0, "10/3");
    run_op(16'd0, 8'd5, 16'd0, 8'd0, 1'b0, "0/5");
    run_op(16'd255, 8'd0, 16'hFFFF, 8'hFF, 1'b1, "255/0");

    // start during RUN is ignored; A/B changes have no effect
    @(negedge clk);
    A = 16'd1000;
    B = 8'd7;
    start = 1'b1;
    @(posedge clk);
    #2 start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    A = 16'd50;
    B = 8'd5;
    start = 1'b1;
    @(posedge clk);
    #2 start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    check("ignore done seen", 32'(got), 32'd1);
    check("ignore Q", 32'(Q), 32'd142);
    check("ignore R", 32'(R), 32'd6);

    // asynchronous reset mid-operation
    @(negedge clk);
    A = 16'd1000;
    B = 8'd7;
    start = 1'b1;
    @(posedge clk);
    #2 start = 1'b0;
    repeat (7) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("async rst Q", 32'(Q), 32'd0);
    check("async rst R", 32'(R), 32'd0);
    check("async rst busy", 32'(busy), 32'd0);
    check("async rst done", 32'(done), 32'd0);
    check("async rst dbz", 32'(dbz), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("no done after rst", done_cnt, 0);
    run_op(16'd1000, 8'd7, 16'd142, 8'd6, 1'b0, "after rst");

    // randomized regression, mixing idle gaps with back-to-back starts
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom_range(0, 65535));
      if (i % 4 == 0) rb = 8'($urandom_range(1, 15));
      else            rb = 8'($urandom_range(1, 255));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_rand(ra, rb);
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
